// File: rtl/alu_exec_unit.sv
// ALU execute unit with valid/ready handshake and optional shift-add multiplier.
// Define ALU_EXEC_UNIT_MUL_EN to enable the multi-cycle MUL (FuncCode 011000).
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       AluOp,
    input  logic [5:0]       FuncCode,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             IllegalOp
);

`ifdef ALU_EXEC_UNIT_MUL_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DONE    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOR, OP_SLT, OP_MUL
    } op_t;

    state_t           state;
    op_t              op;
    logic             illegal;
    logic             sltBit;
    logic [WIDTH-1:0] aluRes;
    logic [WIDTH-1:0] resultQ;
    logic             zeroQ;
    logic             illegalQ;

    always_comb begin
        op      = OP_AND;
        illegal = 1'b0;
        case (AluOp)
            3'b000: begin
                case (FuncCode)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
`ifdef ALU_EXEC_UNIT_MUL_EN
                    6'b011000: op = OP_MUL;
`endif
                    default:   illegal = 1'b1;
                endcase
            end
            3'b001:  op = OP_SUB;
            3'b010:  op = OP_ADD;
            3'b011:  op = OP_AND;
            3'b100:  op = OP_SLT;
            3'b101:  op = OP_OR;
            default: illegal = 1'b1;
        endcase
    end

    assign sltBit = $signed(OpA) < $signed(OpB);

    always_comb begin
        aluRes = '0;
        case (op)
            OP_ADD:  aluRes = OpA + OpB;
            OP_SUB:  aluRes = OpA - OpB;
            OP_AND:  aluRes = OpA & OpB;
            OP_OR:   aluRes = OpA | OpB;
            OP_XOR:  aluRes = OpA ^ OpB;
            OP_NOR:  aluRes = ~(OpA | OpB);
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, sltBit};
            default: aluRes = '0;
        endcase
    end

`ifdef ALU_EXEC_UNIT_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mulNext;

    // Only the low WIDTH bits of the product are kept, so mcand may overflow.
    assign mulNext = prod + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            resultQ  <= '0;
            zeroQ    <= 1'b1;
            illegalQ <= 1'b0;
`ifdef ALU_EXEC_UNIT_MUL_EN
            count    <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        illegalQ <= illegal;
`ifdef ALU_EXEC_UNIT_MUL_EN
                        if (op == OP_MUL) begin
                            state  <= MUL_RUN;
                            count  <= '0;
                            prod   <= '0;
                            mcand  <= OpA;
                            mplier <= OpB;
                        end else
`endif
                        begin
                            state   <= DONE;
                            resultQ <= aluRes;
                            zeroQ   <= (aluRes == '0);
                        end
                    end
                end
`ifdef ALU_EXEC_UNIT_MUL_EN
                MUL_RUN: begin
                    prod   <= mulNext;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state   <= DONE;
                        resultQ <= mulNext;
                        zeroQ   <= (mulNext == '0);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Result    = resultQ;
    assign Zero      = zeroQ;
    assign IllegalOp = illegalQ;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (WIDTH=32).
// MUL vectors run only when ALU_EXEC_UNIT_MUL_EN is defined.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [2:0]  aluOp;
    logic [5:0]  funcCode;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        zero;
    logic        illegalOp;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .AluOp     (aluOp),
        .FuncCode  (funcCode),
        .OpA       (opA),
        .OpB       (opB),
        .out_valid (outValid),
        .out_ready (outReady),
        .Result    (result),
        .Zero      (zero),
        .IllegalOp (illegalOp)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [63:0] obs, input logic [63:0] exp,
                         input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic runOp(input logic [2:0] op, input logic [5:0] fc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expIll,
                         input int expLat, input int hold, input string tag);
        int lat;
        @(negedge clk);
        check(inReady, 1, {tag, ".inReady"});
        inValid  = 1'b1;
        aluOp    = op;
        funcCode = fc;
        opA      = a;
        opB      = b;
        outReady = 1'b0;
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        opA      = $urandom;
        opB      = $urandom;
        aluOp    = 3'($urandom);
        funcCode = 6'($urandom);
        lat = 1;
        while (!outValid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(lat, expLat, {tag, ".latency"});
        check(result, expRes, {tag, ".Result"});
        check(zero, expRes == 32'd0, {tag, ".Zero"});
        check(illegalOp, expIll, {tag, ".IllegalOp"});
        check(inReady, 0, {tag, ".busy"});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            opA = $urandom;
            check({outValid, inReady}, 2'b10, {tag, ".holdHs"});
            check({result, zero, illegalOp},
                  {expRes, expRes == 32'd0, expIll}, {tag, ".holdData"});
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check({outValid, inReady}, 2'b01, {tag, ".xfer"});
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        aluOp    = '0;
        funcCode = '0;
        opA      = '0;
        opB      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check({inReady, outValid}, 2'b10, "rst.hs");
        check({result, zero, illegalOp}, {32'd0, 1'b1, 1'b0}, "rst.data");

        runOp(3'b000, 6'b100000, 32'd5, 32'd7, 32'd12, 0, 1, 0, "add");
        runOp(3'b001, 6'd0, 32'h1234, 32'h1234, 32'd0, 0, 1, 0, "beq");
        runOp(3'b000, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 1, 0, "slt");
        runOp(3'b100, 6'd0, 32'd5, 32'hFFFFFFFD, 32'd0, 0, 1, 0, "slti");
        runOp(3'b000, 6'b100010, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 1, 0, "sub");
        runOp(3'b010, 6'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 0, "addwrap");
        runOp(3'b011, 6'd0, 32'hF0, 32'h3C, 32'h30, 0, 1, 0, "andi");
        runOp(3'b101, 6'd0, 32'hF0, 32'h0F, 32'hFF, 0, 1, 0, "ori");
        runOp(3'b000, 6'b100110, 32'hFF00, 32'h0FF0, 32'hF0F0, 0, 1, 0, "xor");
        runOp(3'b000, 6'b100111, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 1, 0, "nor");
        runOp(3'b110, 6'd0, 32'hF0, 32'h3C, 32'h30, 1, 1, 0, "ill110");
        runOp(3'b111, 6'd0, 32'hF0, 32'h3C, 32'h30, 1, 1, 0, "ill111");
        runOp(3'b000, 6'b111111, 32'hF0, 32'h3C, 32'h30, 1, 1, 0, "illfn");
        runOp(3'b000, 6'b100000, 32'd9, 32'd1, 32'd10, 0, 1, 3, "bp");

`ifdef ALU_EXEC_UNIT_MUL_EN
        runOp(3'b000, 6'b011000, 32'd6, 32'd7, 32'd42, 0, 33, 0, "mul");
        runOp(3'b000, 6'b011000, 32'h10000, 32'h10000, 32'd0, 0, 33, 0,
              "mulz");
        runOp(3'b000, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0, 33,
              2, "mulff");
        @(negedge clk);
        inValid  = 1'b1;
        aluOp    = 3'b000;
        funcCode = 6'b011000;
        opA      = 32'd6;
        opB      = 32'd7;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check(inReady, 0, "midmul.busy");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check({outValid, inReady}, 2'b01, "midmul.hs");
        check(result, 32'd0, "midmul.Result");
        runOp(3'b000, 6'b100000, 32'd1, 32'd1, 32'd2, 0, 1, 0, "postrst");
`else
        runOp(3'b000, 6'b011000, 32'd6, 32'd7, 32'd6, 1, 1, 0, "nomul");
`endif

        @(negedge clk);
        reset    = 1'b1;
        inValid  = 1'b1;
        aluOp    = 3'b010;
        opA      = 32'd1;
        opB      = 32'd1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        inValid = 1'b0;
        check({outValid, inReady}, 2'b01, "rstreq.hs");
        @(posedge clk);
        #1;
        check(outValid, 0, "rstreq.noacc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 The block SHALL take parameter `WIDTH`, default 32: operand and result width in bits, minimum 4.
REQ-003 Port `clk`: input, 1 bit; rising-edge clock.
REQ-004 Port `reset`: input, 1 bit; synchronous, active-high reset.
REQ-005 Port `in_valid`: input, 1 bit; the request on AluOp/FuncCode/OpA/OpB is valid.
REQ-006 Port `in_ready`: output, 1 bit; the block accepts a request this cycle.
REQ-007 Port `AluOp`: input, 3 bits; operation class from main control.
REQ-008 Port `FuncCode`: input, 6 bits; R-type function field.
REQ-009 Port `OpA`: input, WIDTH bits; operand A.
REQ-010 Port `OpB`: input, WIDTH bits; operand B.
REQ-011 Port `out_valid`: output, 1 bit; Result, Zero and IllegalOp are valid.
REQ-012 Port `out_ready`: input, 1 bit; the consumer accepts the result.
REQ-013 Port `Result`: output, WIDTH bits; operation result.
REQ-014 Port `Zero`: output, 1 bit; high when Result is all zeros.
REQ-015 Port `IllegalOp`: output, 1 bit; the AluOp/FuncCode combination is undefined.

Function
REQ-016 The block SHALL decode AluOp as follows: 000 = R-type (per FuncCode); 001 = SUB (BEQ); 010 = ADD (ADDI/LW/SW); 011 = AND (ANDI); 100 = SLT (SLTI); 101 = OR (ORI); 110 and 111 = AND with IllegalOp=1.
REQ-017 For R-type, the block SHALL decode FuncCode as follows: 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 011000 MUL (see Configuration); any other value executes AND with IllegalOp=1.
REQ-018 ADD and SUB SHALL be modulo 2^WIDTH. SLT SHALL be a two's-complement signed compare, giving Result = {WIDTH-1 zeros, OpA<OpB}.
REQ-019 The state machine SHALL have three states: IDLE, MUL_RUN and DONE.
REQ-020 `in_ready` SHALL equal (state == IDLE). A request is accepted when in_valid && in_ready; OpA, OpB and the decoded operation are captured at acceptance.
REQ-021 Single-cycle operations accepted in IDLE SHALL go to DONE on the next edge, giving a latency of 1 cycle from acceptance to out_valid.
REQ-022 MUL accepted in IDLE SHALL go to MUL_RUN with a count of 0.
REQ-023 MUL_RUN SHALL perform one shift-add step per cycle for WIDTH cycles, then go to DONE, giving a latency of WIDTH+1 cycles.
REQ-024 The MUL result SHALL be the low WIDTH bits of the unsigned product.
REQ-025 In DONE, out_valid SHALL be 1. Result, Zero and IllegalOp SHALL be registered and held stable until out_valid && out_ready.
REQ-026 On out_valid && out_ready, the block SHALL return to IDLE. A new request cannot be accepted in that same cycle.
REQ-027 Inputs other than in_valid SHALL be ignored outside acceptance cycles. in_valid asserted while in_ready=0 SHALL be held off by the requester.
REQ-028 Zero SHALL be computed from the final Result, including for MUL.

Reset
REQ-029 When reset=1 at a clock edge, the block SHALL enter IDLE in every state, including mid-MUL_RUN and DONE, abandoning any operation in progress.
REQ-030 After reset, the output values SHALL be: in_ready=1, out_valid=0, Result=0, Zero=1, IllegalOp=0, internal count=0, partial product=0.
REQ-031 A request presented in the same cycle as reset SHALL NOT be accepted.

Configuration
REQ-032 When macro `ALU_EXEC_UNIT_MUL_EN` is defined, FuncCode 011000 under AluOp 000 SHALL execute the multi-cycle MUL per REQ-022 to REQ-024.
REQ-033 When `ALU_EXEC_UNIT_MUL_EN` is undefined, there SHALL be no MUL_RUN state or multiplier datapath. FuncCode 011000 SHALL execute AND with IllegalOp=1, with a latency of 1.

Verification
REQ-034 ADD: AluOp=000, FuncCode=100000, OpA=5, OpB=7 -> out_valid 1 cycle after acceptance, Result=12, Zero=0, IllegalOp=0.
REQ-035 BEQ compare: AluOp=001, OpA=OpB=0x00001234 -> Result=0, Zero=1. SLT: FuncCode=101010, OpA=0xFFFFFFFF, OpB=1 -> Result=1.
REQ-036 MUL (macro defined, WIDTH=32): OpA=6, OpB=7 -> in_ready=0 for 33 cycles, then Result=42. OpA=OpB=0x00010000 -> Result=0, Zero=1.
REQ-037 Backpressure: out_ready held 0 for 3 cycles in DONE -> Result and flags stable and in_ready=0; transfer occurs on the cycle out_ready=1; in_ready=1 on the next cycle.
REQ-038 Reset asserted 10 cycles into a MUL -> on the next cycle out_valid=0, in_ready=1, Result=0. A subsequent ADD 1+1 returns 2.
REQ-039 Illegal operations: AluOp=110, OpA=0xF0, OpB=0x3C -> Result=0x30, IllegalOp=1. FuncCode=011000 with the macro undefined -> AND result, IllegalOp=1, latency 1.
